// File: rtl/controle_pc_pkg.sv
// controle_pc_pkg: state encodings and state width shared by the PC sequencer
package controle_pc_pkg;
  localparam int ESTADO_W = 2;
  typedef enum logic [ESTADO_W-1:0] {
    BUSCA   = 2'd0,
    ESPERA  = 2'd1,
    EXECUTA = 2'd2,
    PARADO  = 2'd3
  } estado_t;
endpackage

// File: rtl/controle_pc_pilha_retorno.sv
// pilha_retorno: DEPTH x ADDR_WIDTH return-address LIFO; ports clock/reset (sync, active-low), push/pop/din in, dout/full/empty out
module pilha_retorno #(
  parameter int ADDR_WIDTH = 13,
  parameter int DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] din,
  output logic [ADDR_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  logic [PW-1:0] sp;
  logic [ADDR_WIDTH-1:0] mem [DEPTH];
  assign full = sp == PW'(DEPTH);
  assign empty = sp == '0;
  assign dout = mem[IW'(sp - 1'b1)];
  always_ff @(posedge clock) begin
    if (!reset) sp <= '0;
    else if (push && !full) begin
      mem[IW'(sp)] <= din;
      sp <= sp + 1'b1;
    end else if (pop && !empty) sp <= sp - 1'b1;
  end
endmodule

// File: rtl/controle_pc.sv
// controle_pc: PC sequencer (fetch/wait/execute/halt); clock, reset (sync, active-low), imem req/ack, datapath valid/done, pc_atual/estado out; PILHA_RETORNO_EN adds chamada/retorno/erro_pilha return stack
module controle_pc
  import controle_pc_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter int STACK_DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] imediato,
  input  logic                  mux_branch,
  input  logic                  halt,
  input  logic                  resume,
`ifdef PILHA_RETORNO_EN
  input  logic                  chamada,
  input  logic                  retorno,
  output logic                  erro_pilha,
`endif
  output logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  instr_valida,
  input  logic                  exec_done,
  output logic [ADDR_WIDTH-1:0] pc_atual,
  output logic [ESTADO_W-1:0]   estado
);
  estado_t st, nx;
  logic [ADDR_WIDTH-1:0] pc_nx, pc_inc, alvo;
  logic done;
  logic unused_imediato;
  assign unused_imediato = ^imediato[DATA_WIDTH-1:ADDR_WIDTH];
  assign alvo = imediato[ADDR_WIDTH-1:0];
  assign pc_inc = pc_atual + ADDR_WIDTH'(1);
  assign done = st == EXECUTA && exec_done;
  assign estado = st;
`ifdef PILHA_RETORNO_EN
  logic push, pop, full, empty, erro_nx;
  logic [ADDR_WIDTH-1:0] topo;
  pilha_retorno #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(STACK_DEPTH)) u_pilha (
    .clock(clock), .reset(reset), .push(push), .pop(pop),
    .din(pc_inc), .dout(topo), .full(full), .empty(empty)
  );
  assign pop = done && retorno;
  assign push = done && chamada && !retorno;
  assign erro_nx = erro_pilha || (pop && empty) || (push && full);
`endif
  always_comb begin
    nx = st;
    pc_nx = pc_atual;
    nx = st == BUSCA   ? ESPERA :
         st == ESPERA  ? (mem_ack ? EXECUTA : ESPERA) :
         st == EXECUTA ? (exec_done ? (halt ? PARADO : BUSCA) : EXECUTA) :
                         (resume ? BUSCA : PARADO);
`ifdef PILHA_RETORNO_EN
    pc_nx = !done      ? pc_atual :
            retorno    ? (empty ? pc_inc : topo) :
            chamada    ? alvo :
            mux_branch ? alvo : pc_inc;
`else
    pc_nx = !done ? pc_atual : mux_branch ? alvo : pc_inc;
`endif
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      st <= BUSCA;
      pc_atual <= RESET_ADDR;
      mem_req <= 1'b0;
      instr_valida <= 1'b0;
`ifdef PILHA_RETORNO_EN
      erro_pilha <= 1'b0;
`endif
    end else begin
      st <= nx;
      pc_atual <= pc_nx;
      mem_req <= nx == ESPERA;
      instr_valida <= st == ESPERA && mem_ack;
`ifdef PILHA_RETORNO_EN
      erro_pilha <= erro_nx;
`endif
    end
  end
endmodule

// File: tb/tb_controle_pc.sv
// tb_controle_pc: directed self-checking bench for controle_pc
module tb_controle_pc;
  logic clock = 0, reset = 0, mux_branch = 0, halt = 0, resume = 0, mem_ack = 0, exec_done = 0;
  logic [31:0] imediato = 0;
  logic mem_req, instr_valida;
  logic [12:0] pc_atual;
  logic [1:0] estado;
  int n_chk = 0, n_fail = 0;
`ifdef PILHA_RETORNO_EN
  logic chamada = 0, retorno = 0, erro_pilha;
`endif
  controle_pc dut (
    .clock(clock), .reset(reset), .imediato(imediato), .mux_branch(mux_branch),
    .halt(halt), .resume(resume),
`ifdef PILHA_RETORNO_EN
    .chamada(chamada), .retorno(retorno), .erro_pilha(erro_pilha),
`endif
    .mem_req(mem_req), .mem_ack(mem_ack), .instr_valida(instr_valida),
    .exec_done(exec_done), .pc_atual(pc_atual), .estado(estado)
  );
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_instr(input logic br, input logic [31:0] imm, input logic h, input logic rs);
    step();
    chk("fetch_espera", {30'd0, estado}, 1);
    mem_ack = 1;
    step();
    chk("ack_valida", {31'd0, instr_valida}, 1);
    mem_ack = 0;
    exec_done = 1; mux_branch = br; imediato = imm; halt = h; resume = rs;
    step();
    exec_done = 0; mux_branch = 0; halt = 0; resume = 0;
  endtask
  initial begin
    mem_ack = 1;
    step(); step();
    chk("rst_pc", {19'd0, pc_atual}, 0);
    chk("rst_estado", {30'd0, estado}, 0);
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_valida", {31'd0, instr_valida}, 0);
    mem_ack = 0;
    reset = 1;
    step(); chk("req_c1", {31'd0, mem_req}, 1);
    step(); chk("req_c2", {31'd0, mem_req}, 1);
    step(); chk("req_c3", {31'd0, mem_req}, 1);
    chk("espera_hold", {30'd0, estado}, 1);
    mem_ack = 1;
    step();
    chk("ack_req_low", {31'd0, mem_req}, 0);
    chk("ack_valida1", {31'd0, instr_valida}, 1);
    chk("ack_executa", {30'd0, estado}, 2);
    mem_ack = 0;
    step();
    chk("valida_pulse", {31'd0, instr_valida}, 0);
    chk("exec_hold_pc", {19'd0, pc_atual}, 0);
    exec_done = 1;
    step();
    exec_done = 0;
    chk("pc_inc", {19'd0, pc_atual}, 1);
    chk("back_busca", {30'd0, estado}, 0);
    run_instr(1, 5, 0, 0);
    chk("br_to5", {19'd0, pc_atual}, 5);
    run_instr(1, 32'h0000_1ABC, 0, 0);
    chk("br_1abc", {19'd0, pc_atual}, 32'h1ABC);
    run_instr(1, 32'hFFFF_FFFF, 0, 0);
    chk("br_1fff", {19'd0, pc_atual}, 32'h1FFF);
    run_instr(0, 0, 0, 0);
    chk("pc_wrap", {19'd0, pc_atual}, 0);
    run_instr(1, 7, 0, 0);
    run_instr(0, 0, 1, 1);
    chk("halt_wins", {30'd0, estado}, 3);
    chk("halt_pc", {19'd0, pc_atual}, 8);
    mem_ack = 1;
    step();
    mem_ack = 0;
    chk("parado_stay", {30'd0, estado}, 3);
    chk("parado_req", {31'd0, mem_req}, 0);
    resume = 1;
    step();
    resume = 0;
    chk("resume_busca", {30'd0, estado}, 0);
    exec_done = 1; mux_branch = 1; imediato = 32'h55;
    step();
    exec_done = 0; mux_branch = 0;
    chk("resume_req", {31'd0, mem_req}, 1);
    chk("stray_done_pc", {19'd0, pc_atual}, 8);
    reset = 0;
    step();
    chk("midrst_req", {31'd0, mem_req}, 0);
    chk("midrst_pc", {19'd0, pc_atual}, 0);
    chk("midrst_estado", {30'd0, estado}, 0);
    reset = 1;
    resume = 1;
    step();
    resume = 0;
    chk("busca_once", {30'd0, estado}, 1);
    step();
    chk("no_ack_espera", {30'd0, estado}, 1);
    chk("no_ack_valida", {31'd0, instr_valida}, 0);
`ifdef PILHA_RETORNO_EN
    reset = 0;
    step();
    reset = 1;
    run_instr(1, 3, 0, 0);
    chamada = 1;
    run_instr(0, 40, 0, 0);
    chamada = 0;
    chk("call_pc", {19'd0, pc_atual}, 40);
    retorno = 1;
    run_instr(0, 0, 0, 0);
    retorno = 0;
    chk("ret_pc", {19'd0, pc_atual}, 4);
    chk("ret_err", {31'd0, erro_pilha}, 0);
    chamada = 1;
    for (int i = 0; i < 8; i++) run_instr(0, 100 + i, 0, 0);
    chk("call8_err", {31'd0, erro_pilha}, 0);
    run_instr(0, 200, 0, 0);
    chamada = 0;
    chk("call9_err", {31'd0, erro_pilha}, 1);
    chk("call9_pc", {19'd0, pc_atual}, 200);
`endif
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/controle_pc.md
Name: controle_pc

Overview:
- Program-counter sequencer for the single-cycle-per-stage core.
- Owns the PC register, sequences each instruction through fetch, memory wait and execute, and applies the branch/PC+1 next-address rule at the end of execute.
- Handshakes with instruction memory (req/ack) and the datapath (valid/done), and supports halt/resume.

Parameters:
ADDR_WIDTH, 13, PC / instruction-address width
DATA_WIDTH, 32, immediate operand width
RESET_ADDR, 0, PC value loaded on reset and on resume-from-reset
STACK_DEPTH, 8, return-stack entries (only with PILHA_RETORNO_EN)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-low reset
imediato  in  DATA_WIDTH  branch/call target; low ADDR_WIDTH bits used
mux_branch  in  1  take branch; sampled only on exec_done
halt  in  1  stop after current instruction; sampled only on exec_done
resume  in  1  leave PARADO
mem_req  out  1  instruction fetch request, registered
mem_ack  in  1  instruction memory data ready
instr_valida  out  1  one-cycle pulse: fetched instruction presented to datapath
exec_done  in  1  datapath finished current instruction
pc_atual  out  ADDR_WIDTH  current PC, registered
estado  out  2  current FSM state (debug)

Behaviour:
- Interface decision: one clock; reset is synchronous and active-low.
- Reset (reset==0 at a rising edge):
  - pc_atual=RESET_ADDR, estado=BUSCA, mem_req=0, instr_valida=0.
  - Reset has priority over every other input and abandons any state mid-operation. mem_req is low from the next edge.
- States: BUSCA=0, ESPERA=1, EXECUTA=2, PARADO=3.
- BUSCA: set mem_req=1; next state ESPERA. Always exactly one cycle.
- ESPERA: hold mem_req=1 until mem_ack==1. On ack:
  - mem_req=0 and instr_valida=1 for one cycle.
  - Next state EXECUTA.
- EXECUTA: hold pc_atual; wait for exec_done. On exec_done:
  - pc_atual <= mux_branch ? imediato[ADDR_WIDTH-1:0] : pc_atual+1.
  - PC+1 wraps modulo 2^ADDR_WIDTH (all-ones -> 0).
  - Next state is PARADO if halt==1, else BUSCA. The PC update still occurs when halting.
- PARADO: mem_req=0. On resume==1, next state BUSCA with PC unchanged.
- Ignored inputs:
  - mem_ack outside ESPERA.
  - exec_done outside EXECUTA.
  - resume outside PARADO.
- Simultaneous events: halt and resume together at exec_done -> halt wins (enter PARADO; resume is evaluated only from the next cycle).
- Latency: minimum instruction period is 3 cycles (BUSCA, ESPERA with immediate ack, EXECUTA with immediate done). The new PC is visible the cycle after exec_done.
- All outputs are registered; there are no combinational input-to-output paths.

Optional Feature:
PILHA_RETORNO_EN:
- Defined: adds ports chamada (in 1), retorno (in 1) and erro_pilha (out 1, sticky, reset 0). All three are sampled on exec_done; priority is retorno > chamada > mux_branch.
  - chamada: push pc_atual+1 and set PC to imediato.
  - retorno: pop into PC.
  - Push when full: push discarded, PC still jumps, erro_pilha=1.
  - Pop when empty: PC=pc_atual+1, erro_pilha=1.
  - Reset empties the stack.
- Undefined: ports are absent and behaviour is exactly as above.

Decomposition:
- Package controle_pc_pkg: state encodings BUSCA/ESPERA/EXECUTA/PARADO and the 2-bit state width constant.
- One sub-module, pilha_retorno: a LIFO of STACK_DEPTH x ADDR_WIDTH with push/pop/full/empty. Instantiated only under PILHA_RETORNO_EN.

Test Plan:
- Reset, then mem_ack after 2 cycles, then exec_done with mux_branch=0 -> mem_req high 3 cycles; instr_valida one pulse; pc_atual 0->1; estado returns to BUSCA.
- PC=5, exec_done with mux_branch=1, imediato=32'h0000_1ABC -> pc_atual=13'h1ABC next cycle.
- PC=13'h1FFF, exec_done with mux_branch=0 -> pc_atual=0.
- exec_done with halt=1 and resume=1 at PC=7 -> estado=PARADO, pc=8; resume next cycle -> BUSCA, mem_req=1 at pc=8.
- reset=0 asserted while in ESPERA with mem_req=1 -> next edge mem_req=0, pc=RESET_ADDR, estado=BUSCA; a later stray mem_ack is ignored.
- PILHA_RETORNO_EN: chamada at PC=3 to 40, then retorno -> PC 40 then 4. Nine nested calls with depth 8 -> erro_pilha=1 on the ninth.
